// File: rtl/nn_batch_runner.sv
// Batch sequencer: streams NUM_IMAGES images from memory into a classifier and scores its predictions.
// Optional RUN-state watchdog enabled by defining NN_BATCH_TIMEOUT_EN.
module nn_batch_runner #(
  parameter int unsigned dataWidth      = 8,
  parameter int unsigned numInputs      = 784,
  parameter int unsigned numOutputs     = 10,
  parameter int unsigned NUM_IMAGES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned IW = $clog2(numOutputs),
  localparam int unsigned AW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
  localparam int unsigned CW = $clog2(NUM_IMAGES + 1),
  localparam int unsigned DW = numInputs * dataWidth
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] imgAddr,
  input  logic [DW-1:0] imgData,
  input  logic [IW-1:0] labelData,
  output logic [DW-1:0] NNin,
  output logic          NNvalid,
  input  logic [IW-1:0] maxIndex,
  input  logic          maxValid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] imgCount,
  output logic [CW-1:0] correctCount,
  output logic [IW-1:0] lastPred,
  output logic          mismatch,
  output logic          timeoutErr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] img_addr_q, img_addr_d;
  logic [DW-1:0] nn_in_q, nn_in_d;
  logic [IW-1:0] label_q, label_d;
  logic          nn_valid_q, nn_valid_d;
  logic [CW-1:0] img_count_q, img_count_d;
  logic [CW-1:0] correct_q, correct_d;
  logic [IW-1:0] last_pred_q, last_pred_d;
  logic          mismatch_q, mismatch_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic start_batch;
  logic timeout_hit;
  logic score;
  logic last_img;

  assign start_batch = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign score       = (state_q == S_RUN) && (maxValid || timeout_hit);
  assign last_img    = (img_count_q == CW'(NUM_IMAGES - 1));

`ifdef NN_BATCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q;
  logic          timeout_err_q;

  assign timeout_hit = (state_q == S_RUN) && !maxValid && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog counts RUN cycles and is held at zero elsewhere, so it restarts on every RUN entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == S_RUN && !score) ? to_cnt_q + TW'(1) : '0;
      if (start_batch) begin
        timeout_err_q <= 1'b0;
      end else if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeoutErr = timeout_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
  assign timeoutErr         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE,
      S_DONE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (score) state_d = last_img ? S_DONE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; NNvalid drops on the same edge that scores the image.
  always_comb begin
    img_addr_d  = img_addr_q;
    nn_in_d     = nn_in_q;
    label_d     = label_q;
    nn_valid_d  = 1'b0;
    img_count_d = img_count_q;
    correct_d   = correct_q;
    last_pred_d = last_pred_q;
    mismatch_d  = 1'b0;
    busy_d      = (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    case (state_q)
      S_IDLE,
      S_DONE: begin
        if (start) begin
          img_addr_d  = '0;
          img_count_d = '0;
          correct_d   = '0;
          last_pred_d = '0;
        end
      end
      S_LOAD: begin
        nn_in_d = imgData;
        label_d = labelData;
      end
      S_RUN: begin
        nn_valid_d = !score;
        if (score) begin
          img_count_d = img_count_q + CW'(1);
          if (!last_img) img_addr_d = img_addr_q + AW'(1);
          if (maxValid) begin
            last_pred_d = maxIndex;
            if (maxIndex == label_q) correct_d = correct_q + CW'(1);
            else                     mismatch_d = 1'b1;
          end else begin
            mismatch_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      img_addr_q  <= '0;
      nn_in_q     <= '0;
      label_q     <= '0;
      nn_valid_q  <= 1'b0;
      img_count_q <= '0;
      correct_q   <= '0;
      last_pred_q <= '0;
      mismatch_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      img_addr_q  <= img_addr_d;
      nn_in_q     <= nn_in_d;
      label_q     <= label_d;
      nn_valid_q  <= nn_valid_d;
      img_count_q <= img_count_d;
      correct_q   <= correct_d;
      last_pred_q <= last_pred_d;
      mismatch_q  <= mismatch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign imgAddr      = img_addr_q;
  assign NNin         = nn_in_q;
  assign NNvalid      = nn_valid_q;
  assign imgCount     = img_count_q;
  assign correctCount = correct_q;
  assign lastPred     = last_pred_q;
  assign mismatch     = mismatch_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_nn_batch_runner.sv
// Randomized bench for nn_batch_runner: synchronous image/label memory, a delayed-echo classifier stub
// and a per-batch outcome model (counts, last prediction, mismatch pulses, latency).
module tb_nn_batch_runner;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned N_IN   = 16;
  localparam int unsigned N_OUT  = 10;
  localparam int unsigned N_IMG  = 4;
  localparam int unsigned TO     = 16;
  localparam int unsigned IW     = $clog2(N_OUT);
  localparam int unsigned AW     = $clog2(N_IMG);
  localparam int unsigned CW     = $clog2(N_IMG + 1);
  localparam int unsigned DW     = N_IN * DATA_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] imgAddr;
  logic [DW-1:0] imgData;
  logic [IW-1:0] labelData;
  logic [DW-1:0] NNin;
  logic          NNvalid;
  logic [IW-1:0] maxIndex;
  logic          maxValid;
  logic          busy;
  logic          done;
  logic [CW-1:0] imgCount;
  logic [CW-1:0] correctCount;
  logic [IW-1:0] lastPred;
  logic          mismatch;
  logic          timeoutErr;

  int n_checks = 0;
  int n_errors = 0;
  bit overlap_seen = 1'b0;

  logic [DW-1:0] mem_img [N_IMG];
  logic [IW-1:0] mem_lbl [N_IMG];

  always #5 clk = ~clk;

  nn_batch_runner #(
    .dataWidth(DATA_W), .numInputs(N_IN), .numOutputs(N_OUT),
    .NUM_IMAGES(N_IMG), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .imgAddr(imgAddr), .imgData(imgData),
    .labelData(labelData), .NNin(NNin), .NNvalid(NNvalid), .maxIndex(maxIndex),
    .maxValid(maxValid), .busy(busy), .done(done), .imgCount(imgCount),
    .correctCount(correctCount), .lastPred(lastPred), .mismatch(mismatch),
    .timeoutErr(timeoutErr)
  );

  // Memory with one cycle of read latency.
  always @(posedge clk) begin
    imgData   <= mem_img[imgAddr];
    labelData <= mem_lbl[imgAddr];
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < N_IMG; i++) begin
      for (int w = 0; w < DW / 32; w++) mem_img[i][w*32 +: 32] = $urandom();
      mem_lbl[i] = IW'($urandom_range(0, N_OUT - 1));
    end
  endtask

  // Runs one batch from IDLE/DONE. wrong_img<0: all correct. reset_img>=0: abort with reset in that image's RUN.
  task automatic run_batch(input int wrong_img, input bit respond, input bit hold_start,
                           input bit glitch, input int reset_img);
    logic [IW-1:0] resp [N_IMG];
    int exp_correct, img, nv_cnt, cyc, lat, mm_pulses, gap;
    bit finished;
    exp_correct = 0;
    for (int i = 0; i < N_IMG; i++) begin
      resp[i] = (i == wrong_img) ? IW'((32'(mem_lbl[i]) + 1) % N_OUT) : mem_lbl[i];
      if (respond && resp[i] == mem_lbl[i]) exp_correct++;
    end
    img = 0; nv_cnt = 0; cyc = 0; lat = -1; mm_pulses = 0; gap = 0; finished = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    maxValid = glitch;
    maxIndex = IW'($urandom_range(0, N_OUT - 1));
    for (int k = 0; k < 2000 && !finished; k++) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) start = 1'b0;
      maxValid = 1'b0;
      if (busy && done) overlap_seen = 1'b1;
      if (mismatch) mm_pulses++;
      if (done) begin
        finished = 1'b1;
      end else begin
        if (cyc == 1) gap = 0;
        else gap++;
        if (NNvalid) begin
          if (nv_cnt == 0) begin
            if (img == 0) lat = cyc - 1;
            check($sformatf("nnin_img%0d", img), NNin, mem_img[img]);
            if (img == reset_img) begin
              start = 1'b0;
              reset = 1'b1;
              #1;
              check("rst_outputs", DW'({NNvalid, busy, done, imgCount, correctCount, lastPred,
                                       mismatch, timeoutErr, imgAddr}), '0);
              check("rst_nnin", NNin, '0);
              @(negedge clk);
              reset = 1'b0;
              return;
            end
          end
          nv_cnt++;
          if (respond && nv_cnt == 5) begin
            maxValid = 1'b1;
            maxIndex = resp[img];
          end
        end else if (nv_cnt > 0) begin
          if (!respond) check($sformatf("run_len_img%0d", img), DW'(nv_cnt), DW'(TO - 1));
          img++;
          nv_cnt = 0;
          gap = 0;
        end
        if (glitch && gap < 2) begin
          maxValid = 1'b1;
          maxIndex = IW'($urandom_range(0, N_OUT - 1));
        end
      end
    end
    check("batch_done", DW'(finished), DW'(1));
    check("start_to_nnvalid", DW'(lat), DW'(3));
    check("busy_at_done", DW'(busy), DW'(0));
    check("img_count", DW'(imgCount), DW'(N_IMG));
    check("correct_count", DW'(correctCount), DW'(exp_correct));
    check("last_pred", DW'(lastPred), respond ? DW'(resp[N_IMG-1]) : DW'(0));
    check("mismatch_pulses", DW'(mm_pulses), DW'(N_IMG - exp_correct));
    check("timeout_err", DW'(timeoutErr), DW'(!respond));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; maxValid = 1'b0; maxIndex = '0;
    fill_mem();
    repeat (3) @(negedge clk);
    check("reset_state", DW'({busy, done, NNvalid, imgCount, correctCount, mismatch}), '0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_no_activity", DW'({busy, done, NNvalid, imgAddr}), '0);

    run_batch(-1, 1'b1, 1'b0, 1'b0, -1);
    repeat (3) @(negedge clk);
    check("done_hold", DW'({done, imgCount, correctCount}), DW'({1'b1, CW'(N_IMG), CW'(N_IMG)}));

    fill_mem();
    run_batch(2, 1'b1, 1'b0, 1'b0, -1);

    fill_mem();
    run_batch(-1, 1'b1, 1'b0, 1'b0, 1);
    repeat (3) @(negedge clk);
    check("idle_after_rst", DW'({busy, done, NNvalid}), '0);
    run_batch(-1, 1'b1, 1'b0, 1'b0, -1);

    // start held high with stray maxValid in IDLE/FETCH/LOAD; DONE then restarts at once.
    fill_mem();
    run_batch(-1, 1'b1, 1'b1, 1'b1, -1);
    @(negedge clk);
    check("restart_from_done", DW'({busy, done, imgCount, correctCount}),
          DW'({1'b1, 1'b0, CW'(0), CW'(0)}));
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

`ifdef NN_BATCH_TIMEOUT_EN
    fill_mem();
    run_batch(-1, 1'b0, 1'b0, 1'b0, -1);
`endif

    for (int r = 0; r < 3; r++) begin
      fill_mem();
      run_batch($urandom_range(0, N_IMG) - 1, 1'b1, 1'b0, 1'b0, -1);
    end

    check("busy_done_exclusive", DW'(overlap_seen), DW'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nn_batch_runner.md
NN_BATCH_RUNNER -- requirements
Module: nn_batch_runner

Interface
REQ-001 SHALL have parameter dataWidth, default 8, bits per input pixel.
REQ-002 SHALL have parameter numInputs, default 784, pixels per image.
REQ-003 SHALL have parameter numOutputs, default 10, NN classes; IW = clog2(numOutputs).
REQ-004 SHALL have parameter NUM_IMAGES, default 8, images per batch (>=1); AW = max(1, clog2(NUM_IMAGES)), CW = clog2(NUM_IMAGES+1).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 4096, RUN-state watchdog limit (used only under TIMEOUT_EN).
REQ-006 SHALL have one clock and an asynchronous active-high reset: clk  in  1  clock; reset  in  1  async active-high reset.
REQ-007 start  in  1  level-sampled batch start request.
REQ-008 imgAddr  out  AW  image/label memory address.
REQ-009 imgData  in  numInputs*dataWidth  image word, valid 1 cycle after imgAddr.
REQ-010 labelData  in  IW  expected class, valid 1 cycle after imgAddr.
REQ-011 NNin  out  numInputs*dataWidth  registered image to network.
REQ-012 NNvalid  out  1  network input valid.
REQ-013 maxIndex  in  IW  network predicted class.
REQ-014 maxValid  in  1  prediction valid.
REQ-015 busy  out  1  batch in progress; done  out  1  batch complete (level).
REQ-016 imgCount  out  CW  images scored; correctCount  out  CW  correct predictions.
REQ-017 lastPred  out  IW  most recent prediction; mismatch  out  1  one-cycle pulse on wrong prediction; timeoutErr  out  1  sticky watchdog flag.

Function
REQ-018 SHALL implement states IDLE, FETCH, LOAD, RUN, DONE.
REQ-019 IDLE: start=1 -> FETCH, clear imgAddr, imgCount, correctCount, lastPred, timeoutErr.
REQ-020 FETCH: imgAddr presented for one cycle -> LOAD.
REQ-021 LOAD: capture imgData into NNin and labelData into an internal label register -> RUN.
REQ-022 RUN: NNvalid=1 every cycle; NNin held stable from LOAD until the next LOAD.
REQ-023 NNvalid SHALL first rise exactly 3 cycles after the edge at which start is sampled in IDLE (or DONE).
REQ-024 RUN with maxValid=1 at an edge: lastPred<=maxIndex, imgCount+=1, correctCount+=1 iff maxIndex==label, else mismatch=1 the following cycle only.
REQ-025 Leaving RUN: if imgCount (post-increment) == NUM_IMAGES -> DONE, else imgAddr+=1 -> FETCH; NNvalid=0 from that cycle.
REQ-026 maxValid in any state other than RUN SHALL be ignored.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 busy=1 in FETCH, LOAD, RUN; done=1 only in DONE; never both high.
REQ-029 DONE: counters and lastPred held; start=1 -> FETCH with clears as REQ-019.
REQ-030 imgAddr SHALL never exceed NUM_IMAGES-1; counters SHALL never wrap.

Reset
REQ-031 reset=1 SHALL asynchronously force IDLE and all outputs/registers to 0 (NNin, NNvalid, imgAddr, counters, lastPred, mismatch, timeoutErr, busy, done), including mid-batch.
REQ-032 After reset release, no activity until start=1 is sampled.

Configuration
REQ-033 With macro NN_BATCH_TIMEOUT_EN defined: a counter clears on RUN entry; when it reaches TIMEOUT_CYCLES without maxValid, the image is scored incorrect (imgCount+=1, mismatch pulse, lastPred unchanged), timeoutErr set (sticky until next start/reset), and REQ-025 transition taken.
REQ-034 Without NN_BATCH_TIMEOUT_EN: no watchdog logic; RUN waits indefinitely; timeoutErr tied 0.

Verification
REQ-035 NUM_IMAGES=4, NN stub echoes label after 5 cycles -> done=1, imgCount=4, correctCount=4, mismatch never pulses.
REQ-036 Same, stub returns label+1 for image 2 -> correctCount=3, exactly one mismatch pulse, lastPred=label of image 3.
REQ-037 reset pulsed during RUN of image 1 -> all outputs 0 immediately; subsequent start completes batch with correctCount=4.
REQ-038 start held high throughout batch and maxValid pulsed in IDLE/FETCH/LOAD -> no restart, counts unaffected; start sampled in DONE restarts with counters cleared.
REQ-039 NN_BATCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, stub never responds -> each image leaves RUN after 16 cycles, done=1, imgCount=4, correctCount=0, timeoutErr=1.
REQ-040 Start edge to first NNvalid rise measured -> exactly 3 cycles; NNin equals memory word at address 0 while NNvalid=1.
